// File: rtl/word_line_pkg.sv
// word_line_pkg
// Shared definitions for the word-line FIFO slice.
//   mode_t           : 3-bit read transform select carried on the FIFO bus
//   MODE_PASS        : popped word is presented unchanged
//   MODE_SHIFTRIGHT2 : popped word is presented logically shifted right by 2
//   is_shift_mode()  : true only for MODE_SHIFTRIGHT2; every other code is a pass
package word_line_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_PASS        = 3'b000;
    localparam mode_t MODE_SHIFTRIGHT2 = 3'b001;

    function automatic logic is_shift_mode(input mode_t mode);
        return (mode == MODE_SHIFTRIGHT2);
    endfunction

endpackage

// File: rtl/word_line_fifo_if.sv
// word_line_fifo_if
// Bus between a producer/consumer and the word-line FIFO.
//   load, number    : write strobe and write data
//   read, mode      : pop request and read transform select
//   data_out        : registered popped word, valid_out marks a fresh pop
//   full, empty     : registered occupancy flags
//   count           : registered occupancy, log2(DEPTH)+1 bits
//   wrapout         : one-cycle pulse after the write pointer wraps to 0
// Modports: master drives load/number/read/mode, slave (the FIFO) drives the rest.
interface word_line_fifo_if
    import word_line_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic             load;
    logic [WIDTH-1:0] number;
    logic             read;
    mode_t            mode;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             wrapout;

    modport master (
        output load, number, read, mode,
        input  data_out, valid_out, full, empty, count, wrapout
    );

    modport slave (
        input  load, number, read, mode,
        output data_out, valid_out, full, empty, count, wrapout
    );

endinterface

// File: rtl/word_line_ram.sv
// word_line_ram
// DEPTH x WIDTH storage with one synchronous write port and one synchronous
// read port. The array has no reset.
//   clk              : clock
//   wr_en/wr_addr/wr_data : write port, stored on the rising edge
//   rd_en/rd_addr    : read port, rd_data updates only when rd_en is high
//   rd_data          : registered read data, holds between reads
module word_line_ram #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: a same-address read in this edge still sees the old word,
    // which is what a full FIFO needs on a simultaneous write and pop.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: holding rd_data between reads keeps the last popped word.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/word_line_fifo.sv
// word_line_fifo
// Synchronous FIFO of DEPTH words of WIDTH bits with an optional
// shift-right-by-2 transform applied to popped words.
//   clk   : single clock, all state changes on the rising edge
//   reset : synchronous, active-low; clears pointers, flags and outputs
//   bus   : word_line_fifo_if slave modport (load/number/read/mode in,
//           data_out/valid_out/full/empty/count/wrapout out)
module word_line_fifo
    import word_line_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    word_line_fifo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             full_q;
    logic             empty_q;
    logic             valid_q;
    logic             wrap_q;
    logic             shift_q;
    logic             zero_q;
    logic             pop;
    logic             push;
    logic [WIDTH-1:0] ram_q;

    // A full FIFO can still take a write when a pop frees the slot in the
    // same edge; an empty FIFO never bypasses, so its pop is simply refused.
    assign pop  = bus.read && !empty_q;
    assign push = bus.load && (!full_q || pop);

    word_line_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push && reset),
        .wr_addr (wr_ptr),
        .wr_data (bus.number),
        .rd_en   (pop && reset),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    // Pointer, occupancy and output-qualifier state. zero_q forces data_out
    // to 0 after reset until the first pop, since the RAM output has no reset.
    // shift_q captures the transform chosen in the pop cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            shift_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                shift_q <= is_shift_mode(bus.mode);
                zero_q  <= 1'b0;
            end
            case ({push, pop})
                2'b10: begin
                    count_q <= count_q + CW'(1);
                    full_q  <= (count_q == CW'(DEPTH - 1));
                    empty_q <= 1'b0;
                end
                2'b01: begin
                    count_q <= count_q - CW'(1);
                    full_q  <= 1'b0;
                    empty_q <= (count_q == CW'(1));
                end
                default: begin
                end
            endcase
            valid_q <= pop;
            wrap_q  <= push && (wr_ptr == AW'(DEPTH - 1));
        end
    end

    assign bus.data_out  = zero_q ? '0 : (shift_q ? (ram_q >> 2) : ram_q);
    assign bus.valid_out = valid_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.count     = count_q;
    assign bus.wrapout   = wrap_q;

endmodule

// File: tb/tb_word_line_fifo.sv
// tb_word_line_fifo
// Scoreboard bench for word_line_fifo (DEPTH=8, WIDTH=24). Each pop pushes its
// hand-computed word into a queue; a negedge monitor pops and compares every
// time valid_out is seen. Status outputs are checked directly between steps.
module tb_word_line_fifo;
    import word_line_pkg::*;

    localparam int WIDTH = 24;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;

    int checks = 0;
    int errors = 0;
    int wrapCount = 0;
    int wrapBefore;
    logic [WIDTH-1:0] expq[$];
    logic [WIDTH-1:0] expWord;

    always #5 clk = ~clk;

    word_line_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    word_line_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Monitor: every presented word must match the oldest expected pop.
    always @(negedge clk) begin
        if (bus.wrapout) begin
            wrapCount++;
        end
        if (bus.valid_out) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_pop: data_out=%h valid_out=1, required valid_out=0", bus.data_out);
            end else begin
                expWord = expq.pop_front();
                if (bus.data_out !== expWord) begin
                    errors++;
                    $display("[TB] FAIL pop_data: got %h, required %h", bus.data_out, expWord);
                end
            end
        end
    end

    task automatic applyStimulus(input logic ld, input logic [WIDTH-1:0] num,
                                 input logic rd, input mode_t md);
        bus.load   = ld;
        bus.number = num;
        bus.read   = rd;
        bus.mode   = md;
        @(posedge clk);
        #1;
        bus.load   = 1'b0;
        bus.read   = 1'b0;
        bus.mode   = MODE_PASS;
    endtask

    task automatic pushWord(input logic [WIDTH-1:0] v);
        applyStimulus(1'b1, v, 1'b0, MODE_PASS);
    endtask

    task automatic popWord(input mode_t md, input logic [WIDTH-1:0] expected);
        expq.push_back(expected);
        applyStimulus(1'b0, '0, 1'b1, md);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
        end
    endtask

    task automatic checkStatus(input string name, input int cnt, input logic f,
                               input logic e, input logic v);
        checkOutput({name, "_count"}, 32'(bus.count), cnt);
        checkOutput({name, "_full"}, 32'(bus.full), 32'(f));
        checkOutput({name, "_empty"}, 32'(bus.empty), 32'(e));
        checkOutput({name, "_valid"}, 32'(bus.valid_out), 32'(v));
    endtask

    initial begin
        bus.load   = 1'b0;
        bus.number = '0;
        bus.read   = 1'b0;
        bus.mode   = MODE_PASS;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkStatus("reset", 0, 1'b0, 1'b1, 1'b0);
        checkOutput("reset_data_out", 32'(bus.data_out), 0);
        checkOutput("reset_wrapout", 32'(bus.wrapout), 0);
        reset = 1'b1;

        // Three writes, three pops in order
        pushWord(24'h000011);
        pushWord(24'h000022);
        pushWord(24'h000033);
        checkStatus("three_writes", 3, 1'b0, 1'b0, 1'b0);
        popWord(MODE_PASS, 24'h000011);
        popWord(MODE_PASS, 24'h000022);
        popWord(MODE_PASS, 24'h000033);
        checkStatus("three_pops", 0, 1'b0, 1'b1, 1'b1);

        // Fill to DEPTH across the pointer wrap, drop a write, then write+pop
        wrapBefore = wrapCount;
        for (int i = 0; i < DEPTH; i++) begin
            pushWord(24'h0000A1 + WIDTH'(i));
        end
        checkStatus("filled", 8, 1'b1, 1'b0, 1'b0);
        pushWord(24'hFFFFFF);
        checkStatus("dropped_write", 8, 1'b1, 1'b0, 1'b0);
        expq.push_back(24'h0000A1);
        applyStimulus(1'b1, 24'h0000B9, 1'b1, MODE_PASS);
        checkStatus("full_write_pop", 8, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("wrap_pulses", wrapCount - wrapBefore, 1);
        for (int i = 1; i < DEPTH; i++) begin
            popWord(MODE_PASS, 24'h0000A1 + WIDTH'(i));
        end
        popWord(MODE_PASS, 24'h0000B9);
        checkStatus("drained", 0, 1'b0, 1'b1, 1'b1);

        // Shift transform, held data_out, other mode codes pass
        pushWord(24'h00000C);
        popWord(MODE_SHIFTRIGHT2, 24'h000003);
        applyStimulus(1'b0, '0, 1'b0, MODE_PASS);
        checkOutput("held_data_out", 32'(bus.data_out), 32'h000003);
        checkOutput("held_valid", 32'(bus.valid_out), 0);
        pushWord(24'h800004);
        popWord(3'b111, 24'h800004);

        // Pops on an empty FIFO, and write+pop on an empty FIFO
        applyStimulus(1'b0, '0, 1'b1, MODE_PASS);
        checkStatus("empty_pop", 0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 24'h000055, 1'b1, MODE_PASS);
        checkStatus("empty_write_pop", 1, 1'b0, 1'b0, 1'b0);
        popWord(MODE_PASS, 24'h000055);

        // Reset mid-stream overrides a same-cycle write and pop
        for (int i = 0; i < 5; i++) begin
            pushWord(24'h000061 + WIDTH'(i));
        end
        checkStatus("five_writes", 5, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b1, 24'h000099, 1'b1, MODE_PASS);
        checkStatus("mid_reset", 0, 1'b0, 1'b1, 1'b0);
        checkOutput("mid_reset_data_out", 32'(bus.data_out), 0);
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, MODE_PASS);
        checkStatus("post_reset_pop1", 0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, MODE_PASS);
        checkStatus("post_reset_pop2", 0, 1'b0, 1'b1, 1'b0);
        pushWord(24'h000077);
        popWord(MODE_PASS, 24'h000077);
        checkStatus("final_pop", 0, 1'b0, 1'b1, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(expq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/word_line_fifo.md
WORD_LINE_FIFO -- requirements
Module: word_line_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 24, meaning the data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the entry count; it is a power of two, and 2 and 8 are the verified values.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port load, input, 1 bit: write strobe, sampled each cycle.
REQ-006 SHALL have port number, input, WIDTH bits: write data, qualified by load.
REQ-007 SHALL have port read, input, 1 bit: pop request, sampled each cycle.
REQ-008 SHALL have port mode, input, 3 bits: read transform select, 3'b000 = pass and 3'b001 = shiftright2; all other codes behave as pass.
REQ-009 SHALL have port data_out, output, WIDTH bits: registered popped word.
REQ-010 SHALL have port valid_out, output, 1 bit: data_out holds a word popped in the previous cycle.
REQ-011 SHALL have port full, output, 1 bit: count equals DEPTH.
REQ-012 SHALL have port empty, output, 1 bit: count equals 0.
REQ-013 SHALL have port count, output, log2(DEPTH)+1 bits: current occupancy.
REQ-014 SHALL have port wrapout, output, 1 bit: one-cycle pulse when the write pointer wraps from DEPTH-1 to 0.

Function
REQ-015 SHALL accept a write when load=1 and either full=0, or full=1 with a pop in the same cycle; an accepted write stores number at the write pointer, and the pointer advances modulo DEPTH.
REQ-016 SHALL accept a pop when read=1 and empty=0; a pop with empty=1 is ignored and produces valid_out=0 with no state change.
REQ-017 SHALL, on an accepted pop, present the entry at the read pointer on data_out with 1-cycle latency, set valid_out=1 for exactly that cycle, and advance the read pointer modulo DEPTH.
REQ-018 SHALL, when mode=3'b001 in the pop cycle, present data_out as the entry logically shifted right by 2 with zero fill; mode is sampled in the pop cycle only.
REQ-019 SHALL drop a write attempted while full=1 without a same-cycle pop, leaving memory, pointers and count unchanged.
REQ-020 SHALL, on simultaneous accepted write and pop, leave count unchanged; when empty=1, a same-cycle load and read performs the write only and never bypasses.
REQ-021 SHALL hold data_out at its last popped value when valid_out=0.
REQ-022 SHALL update count, full and empty registered in the same edge as the pointer updates; they are never combinationally derived from load or read.
REQ-023 SHALL pulse wrapout in the cycle after the accepted write that moves the write pointer from DEPTH-1 to 0.

Reset
REQ-024 SHALL, when reset=0 at a rising clk edge, set both pointers to 0, count to 0, empty to 1, full to 0, valid_out to 0, wrapout to 0 and data_out to 0.
REQ-025 SHALL let reset override load and read in the same cycle, discarding in-flight operations; memory contents are not cleared.

Structure
REQ-026 SHALL take the mode encodings MODE_PASS=3'b000 and MODE_SHIFTRIGHT2=3'b001 from the shared package word_line_pkg.
REQ-027 SHALL isolate storage in one sub-module, word_line_ram: DEPTH x WIDTH with one synchronous write port and one synchronous read port, and no reset on the array.

Verification
REQ-028 SHALL cover: reset, then 3 writes of 24'h000011, 24'h000022 and 24'h000033 -> count=3, empty=0; 3 pops -> data_out 11, 22, 33, each with valid_out=1, ending with empty=1.
REQ-029 SHALL cover: DEPTH=8, 8 writes -> full=1 and wrapout pulses once; a 9th write of 24'hFFFFFF -> dropped, count stays 8, and the first pop returns the first word.
REQ-030 SHALL cover: a write of 24'h00000C, then a pop with mode=3'b001 -> data_out=24'h000003 with valid_out=1.
REQ-031 SHALL cover: full FIFO with load=1 and read=1 in the same cycle -> count stays 8, the oldest word pops, and the new word is stored at the tail.
REQ-032 SHALL cover: empty FIFO with read=1 -> valid_out=0 and count=0; empty FIFO with load and read together -> count=1 and valid_out=0.
REQ-033 SHALL cover: reset=0 asserted mid-stream with count=5 -> next cycle count=0, empty=1, valid_out=0, and pops remain ignored until a new write.
